man_seq: RTL and testbench



---
 rtl/man_seq_if.sv | 39 +++
 rtl/man_seq.sv | 151 +++++++++++++++
 tb/tb_man_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/man_seq_if.sv
// Bus bundle between a host/engine side (master) and the frame sequencer (slave).
interface man_seq_if #(
   parameter int FPW = 54
);
   logic           start;
   logic           stop;
   logic [FPW-1:0] cfg_x0;
   logic [FPW-1:0] cfg_y0;
   logic [FPW-1:0] cfg_xs;
   logic [FPW-1:0] cfg_ys;
   logic [FPW-1:0] cfg_dx;
   logic [FPW-1:0] cfg_dy;
   logic [5:0]     cfg_zshift;
   logic [15:0]    cfg_nframes;
   logic           man_done;
   logic           man_init;
   logic [FPW-1:0] man_x0;
   logic [FPW-1:0] man_y0;
   logic [FPW-1:0] man_xs;
   logic [FPW-1:0] man_ys;
   logic           busy;
   logic [15:0]    frame_cnt;
   logic           frame_done;
   logic           err_to;

   modport master (
      output start, stop, cfg_x0, cfg_y0, cfg_xs, cfg_ys, cfg_dx, cfg_dy,
             cfg_zshift, cfg_nframes, man_done,
      input  man_init, man_x0, man_y0, man_xs, man_ys, busy, frame_cnt,
             frame_done, err_to
   );

   modport slave (
      input  start, stop, cfg_x0, cfg_y0, cfg_xs, cfg_ys, cfg_dx, cfg_dy,
             cfg_zshift, cfg_nframes, man_done,
      output man_init, man_x0, man_y0, man_xs, man_ys, busy, frame_cnt,
             frame_done, err_to
   );
endinterface

// File: rtl/man_seq.sv
// Frame sequencer for a Mandelbrot engine: loads a frame window, kicks the
// engine, waits for it to finish, then pans/zooms the window for the next frame.
module man_seq #(
   parameter int FPW    = 54,
   parameter int TO_CYC = 1024
) (
   input  logic     clk,
   input  logic     rst_n,
   man_seq_if.slave bus
);
   localparam int WDW = $clog2(TO_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_INIT, S_WAIT_BUSY, S_WAIT_DONE, S_UPDATE
   } state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [1:0]     r_sync;
   logic           w_done_s;
   logic [WDW-1:0] r_wd;
   logic           w_wd_exp;
   logic [FPW-1:0] r_x0;
   logic [FPW-1:0] r_y0;
   logic [FPW-1:0] r_xs;
   logic [FPW-1:0] r_ys;
   logic [FPW-1:0] w_xs_dec;
   logic [FPW-1:0] w_ys_dec;
   logic [15:0]    r_cnt;
   logic [15:0]    w_cnt_inc;
   logic           r_err_to;
   logic           r_stop_pend;
   logic           w_stop_req;
   logic           w_last;
   logic           w_man_init;
   logic           w_busy;
   logic           w_frame_done;

   assign w_done_s   = r_sync[1];
   assign w_wd_exp   = (r_wd == WDW'(TO_CYC - 1));
   assign w_cnt_inc  = r_cnt + 16'd1;
   // A stop arriving in the UPDATE cycle itself still ends after this frame.
   assign w_stop_req = r_stop_pend | bus.stop;
   assign w_last     = (bus.cfg_nframes != 16'd0) && (w_cnt_inc == bus.cfg_nframes);

   // Two-flop synchronizer for the engine's done level; idles high (engine idle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], bus.man_done};
   end

   // Zoom decrement terms; zero shift or shift past the word width means no zoom.
   always_comb begin
      w_xs_dec = '0;
      w_ys_dec = '0;
      if ((bus.cfg_zshift != 6'd0) && (int'(bus.cfg_zshift) < FPW)) begin
         w_xs_dec = r_xs >> bus.cfg_zshift;
         w_ys_dec = r_ys >> bus.cfg_zshift;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic; an engine that never drops done trips the watchdog.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      if (bus.start) w_state_next = S_LOAD;
         S_LOAD:      w_state_next = S_INIT;
         S_INIT:      w_state_next = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!w_done_s)     w_state_next = S_WAIT_DONE;
            else if (w_wd_exp) w_state_next = S_IDLE;
         end
         S_WAIT_DONE: if (w_done_s) w_state_next = S_UPDATE;
         S_UPDATE:    w_state_next = (w_stop_req || w_last) ? S_IDLE : S_INIT;
         default:     w_state_next = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      w_man_init   = 1'b0;
      w_busy       = (r_state != S_IDLE);
      w_frame_done = 1'b0;
      case (r_state)
         S_INIT, S_WAIT_BUSY: w_man_init   = 1'b1;
         S_UPDATE:            w_frame_done = 1'b1;
         default:             ;
      endcase
   end

   // Watchdog counts cycles spent in WAIT_BUSY only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_wd <= '0;
      else if (r_state == S_WAIT_BUSY) r_wd <= r_wd + WDW'(1);
      else                             r_wd <= '0;
   end

   // Stop request is remembered until the sequencer returns to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_stop_pend <= 1'b0;
      else if (w_state_next == S_IDLE) r_stop_pend <= 1'b0;
      else if (bus.stop)               r_stop_pend <= 1'b1;
   end

   // Frame window, frame counter and sticky watchdog error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x0     <= '0;
         r_y0     <= '0;
         r_xs     <= '0;
         r_ys     <= '0;
         r_cnt    <= '0;
         r_err_to <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_cnt    <= '0;
            r_err_to <= 1'b0;
         end
         if (r_state == S_LOAD) begin
            r_x0 <= bus.cfg_x0;
            r_y0 <= bus.cfg_y0;
            r_xs <= bus.cfg_xs;
            r_ys <= bus.cfg_ys;
         end
         if (r_state == S_UPDATE) begin
            r_x0  <= r_x0 + bus.cfg_dx;
            r_y0  <= r_y0 + bus.cfg_dy;
            r_xs  <= r_xs - w_xs_dec;
            r_ys  <= r_ys - w_ys_dec;
            r_cnt <= w_cnt_inc;
         end
         if (r_state == S_WAIT_BUSY && w_done_s && w_wd_exp) r_err_to <= 1'b1;
      end
   end

   assign bus.man_init   = w_man_init;
   assign bus.busy       = w_busy;
   assign bus.frame_done = w_frame_done;
   assign bus.frame_cnt  = r_cnt;
   assign bus.err_to     = r_err_to;
   assign bus.man_x0     = r_x0;
   assign bus.man_y0     = r_y0;
   assign bus.man_xs     = r_xs;
   assign bus.man_ys     = r_ys;
endmodule

// File: tb/tb_man_seq.sv
// Self-checking bench for man_seq: table of full-sequence runs plus hand-written
// watchdog, stop, start+stop and mid-frame reset sequences.
module tb_man_seq;
   localparam int FPW    = 54;
   localparam int TO_CYC = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   man_seq_if #(.FPW(FPW)) bus ();

   man_seq #(.FPW(FPW), .TO_CYC(TO_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_vec   = 0;
   int n_err   = 0;
   int n_pulse = 0;
   bit eng_stuck = 1'b0;

   // Engine model: done falls 4 cycles after init rises, rises 20 cycles later.
   bit eng_act  = 1'b0;
   bit eng_prev = 1'b0;
   int eng_cnt  = 0;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.man_done = 1'b1;
         eng_act = 1'b0;
         eng_prev = 1'b0;
         eng_cnt = 0;
      end else begin
         if (eng_stuck) begin
            bus.man_done = 1'b1;
            eng_act = 1'b0;
         end else if (!eng_act && bus.man_init && !eng_prev) begin
            eng_act = 1'b1;
            eng_cnt = 0;
         end else if (eng_act) begin
            eng_cnt++;
            if (eng_cnt == 4) bus.man_done = 1'b0;
            if (eng_cnt == 24) begin
               bus.man_done = 1'b1;
               eng_act = 1'b0;
            end
         end
         eng_prev = bus.man_init;
      end
   end

   // Count frame_done pulses, sampled mid-cycle.
   always @(negedge clk) if (rst_n && bus.frame_done) n_pulse++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_cfg(input logic [FPW-1:0] x0, y0, xs, ys, dx, dy,
                          input logic [5:0] zs, input logic [15:0] nf);
      bus.cfg_x0 = x0; bus.cfg_y0 = y0; bus.cfg_xs = xs; bus.cfg_ys = ys;
      bus.cfg_dx = dx; bus.cfg_dy = dy; bus.cfg_zshift = zs; bus.cfg_nframes = nf;
   endtask

   task automatic pulse(input bit s, input bit p);
      @(negedge clk);
      bus.start = s; bus.stop = p;
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!bus.busy) begin ok = 1'b1; break; end
      end
      chk(nm, 64'(ok), 64'd1);
   endtask

   task automatic wait_init(input logic lvl, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.man_init == lvl) begin ok = 1'b1; break; end
      end
      chk(nm, 64'(ok), 64'd1);
   endtask

   typedef struct {
      logic [FPW-1:0] x0, y0, xs, ys, dx, dy;
      logic [5:0]     zs;
      logic [15:0]    nf;
      logic [FPW-1:0] ex0, ey0, exs, eys;
      logic [15:0]    ecnt;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int base;
      bus.start = 1'b0; bus.stop = 1'b0;
      set_cfg('0, '0, '0, '0, '0, '0, 6'd0, 16'd0);

      // Multi-frame runs: cfg in, final window / count expected.
      tbl[0] = '{54'h0, 54'h0, 54'h100, 54'h200, 54'h1, 54'h2, 6'd0, 16'd3,
                 54'h3, 54'h6, 54'h100, 54'h200, 16'd3};
      tbl[1] = '{54'h1000, 54'h2000, 54'h100000, 54'h100000, 54'h3FFFFFFFFFFFFB, 54'h5, 6'd2, 16'd1,
                 54'hFFB, 54'h2005, 54'hC0000, 54'hC0000, 16'd1};
      tbl[2] = '{54'h0, 54'h0, 54'h100000, 54'h100000, 54'h3FFFFFFFFFFFFB, 54'h5, 6'd2, 16'd2,
                 54'h3FFFFFFFFFFFF6, 54'hA, 54'h90000, 54'h90000, 16'd2};
      tbl[3] = '{54'h3FFFFFFFFFFFFF, 54'h0, 54'h3, 54'h10, 54'h1, 54'h0, 6'd4, 16'd1,
                 54'h0, 54'h0, 54'h3, 54'hF, 16'd1};
      tbl[4] = '{54'h10, 54'h20, 54'h123, 54'h456, 54'h10, 54'h0, 6'd54, 16'd2,
                 54'h30, 54'h20, 54'h123, 54'h456, 16'd2};
      tbl[5] = '{54'h7, 54'h3FFFFFFFFFFFFE, 54'h100, 54'h1, 54'h0, 54'h3, 6'd1, 16'd3,
                 54'h7, 54'h7, 54'h20, 54'h1, 16'd3};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_init", 64'(bus.man_init), 64'd0);
      chk("rst_cnt", 64'(bus.frame_cnt), 64'd0);
      chk("rst_err", 64'(bus.err_to), 64'd0);
      chk("rst_x0", 64'(bus.man_x0), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven full sequences.
      for (int v = 0; v < 6; v++) begin
         set_cfg(tbl[v].x0, tbl[v].y0, tbl[v].xs, tbl[v].ys, tbl[v].dx, tbl[v].dy,
                 tbl[v].zs, tbl[v].nf);
         base = n_pulse;
         pulse(1'b1, 1'b0);
         wait_idle($sformatf("v%0d_idle", v));
         chk($sformatf("v%0d_x0", v), 64'(bus.man_x0), 64'(tbl[v].ex0));
         chk($sformatf("v%0d_y0", v), 64'(bus.man_y0), 64'(tbl[v].ey0));
         chk($sformatf("v%0d_xs", v), 64'(bus.man_xs), 64'(tbl[v].exs));
         chk($sformatf("v%0d_ys", v), 64'(bus.man_ys), 64'(tbl[v].eys));
         chk($sformatf("v%0d_cnt", v), 64'(bus.frame_cnt), 64'(tbl[v].ecnt));
         chk($sformatf("v%0d_pulses", v), 64'(n_pulse - base), 64'(tbl[v].ecnt));
         chk($sformatf("v%0d_err", v), 64'(bus.err_to), 64'd0);
         $display("vector %0d: x0=%h xs=%h cnt=%0d", v, bus.man_x0, bus.man_xs, bus.frame_cnt);
      end

      // Watchdog: done never drops; err_to exactly TO_CYC cycles after WAIT_BUSY entry.
      eng_stuck = 1'b1;
      set_cfg(54'h1, 54'h2, 54'h3, 54'h4, 54'h0, 54'h0, 6'd0, 16'd1);
      base = n_pulse;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= TO_CYC + 2; k++) begin
         @(posedge clk); #1;
         if (k == TO_CYC + 1) begin
            chk("wd_err_early", 64'(bus.err_to), 64'd0);
            chk("wd_busy_early", 64'(bus.busy), 64'd1);
            chk("wd_init_early", 64'(bus.man_init), 64'd1);
         end
         if (k == TO_CYC + 2) begin
            chk("wd_err", 64'(bus.err_to), 64'd1);
            chk("wd_busy", 64'(bus.busy), 64'd0);
            chk("wd_init", 64'(bus.man_init), 64'd0);
         end
      end
      chk("wd_pulses", 64'(n_pulse - base), 64'd0);
      $display("watchdog: err_to=%0d busy=%0d", bus.err_to, bus.busy);
      eng_stuck = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("wd_clear", 64'(bus.err_to), 64'd0);
      wait_idle("wd_rerun_idle");
      chk("wd_rerun_cnt", 64'(bus.frame_cnt), 64'd1);

      // Stop mid WAIT_DONE of frame 5 with unlimited frames.
      set_cfg(54'h0, 54'h0, 54'h40, 54'h40, 54'h1, 54'h2, 6'd0, 16'd0);
      base = n_pulse;
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 2000 && (n_pulse - base) < 4; i++) @(negedge clk);
      chk("stop_four", 64'(n_pulse - base), 64'd4);
      wait_init(1'b1, "stop_f5_init");
      wait_init(1'b0, "stop_f5_wdone");
      repeat (3) @(negedge clk);
      pulse(1'b0, 1'b1);
      chk("stop_still_busy", 64'(bus.busy), 64'd1);
      wait_idle("stop_idle");
      chk("stop_cnt", 64'(bus.frame_cnt), 64'd5);
      chk("stop_pulses", 64'(n_pulse - base), 64'd5);
      chk("stop_x0", 64'(bus.man_x0), 64'd5);
      $display("stop: cnt=%0d x0=%h", bus.frame_cnt, bus.man_x0);

      // Stop alone in IDLE is ignored; the next run uses its full frame count.
      pulse(1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("idle_stop_busy", 64'(bus.busy), 64'd0);
      set_cfg(54'h0, 54'h0, 54'h40, 54'h40, 54'h1, 54'h1, 6'd0, 16'd2);
      base = n_pulse;
      pulse(1'b1, 1'b0);
      wait_idle("idle_stop_run");
      chk("idle_stop_cnt", 64'(bus.frame_cnt), 64'd2);

      // Start and stop together: exactly one frame.
      set_cfg(54'h0, 54'h0, 54'h40, 54'h40, 54'h1, 54'h1, 6'd0, 16'd0);
      base = n_pulse;
      pulse(1'b1, 1'b1);
      wait_idle("ss_idle");
      chk("ss_cnt", 64'(bus.frame_cnt), 64'd1);
      chk("ss_pulses", 64'(n_pulse - base), 64'd1);

      // Asynchronous reset during WAIT_DONE aborts the frame.
      set_cfg(54'h55, 54'h66, 54'h77, 54'h88, 54'h1, 54'h1, 6'd0, 16'd3);
      base = n_pulse;
      pulse(1'b1, 1'b0);
      wait_init(1'b1, "rst_f1_init");
      wait_init(1'b0, "rst_f1_wdone");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_init", 64'(bus.man_init), 64'd0);
      chk("arst_fd", 64'(bus.frame_done), 64'd0);
      chk("arst_cnt", 64'(bus.frame_cnt), 64'd0);
      chk("arst_x0", 64'(bus.man_x0), 64'd0);
      chk("arst_ys", 64'(bus.man_ys), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("arst_pulses", 64'(n_pulse - base), 64'd0);
      chk("arst_idle", 64'(bus.busy), 64'd0);
      $display("reset abort: busy=%0d cnt=%0d", bus.busy, bus.frame_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "simulation time limit");
   end
endmodule
